mesh_sort_pe: RTL
=================

Name: mesh_sort_pe

Overview:
- Processing element for the Nanci 2-D mesh sorter.
- Holds one DATA_WIDTH key at a fixed grid position (ROW, COL) in a SQRT_N x SQRT_N mesh.
- Runs shearsort in lockstep with all other PEs: alternating odd-even transposition row phases (snake order) and column phases, finishing with the mesh in snake-sorted order.
- Successor to the fixed single-PE block: width, grid size and position are parametrised, and it adds a load/start/done handshake and phase control.

Parameters:
- DATA_WIDTH, 16, key width in bits.
- SQRT_N, 4, mesh side length (>=1).
- ROW, 0, this PE's row index (0 = top).
- COL, 0, this PE's column index (0 = left).
- PHASE_W, 2*$clog2(SQRT_N)+2, width of the phase counter.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- i_load_valid, in, 1, write i_load_data into the key register.
- i_load_data, in, DATA_WIDTH, key to load.
- i_start, in, 1, begin a sort.
- i_PE_l, in, DATA_WIDTH, left neighbour's o_PE (tie to 0 at edge).
- i_PE_r, in, DATA_WIDTH, right neighbour's o_PE.
- i_PE_u, in, DATA_WIDTH, upper neighbour's o_PE.
- i_PE_d, in, DATA_WIDTH, lower neighbour's o_PE.
- o_PE, out, DATA_WIDTH, registered current key.
- o_busy, out, 1, sort in progress.
- o_done, out, 1, sort complete; held until the next load or start.
- o_phase, out, PHASE_W, current phase index.

Behaviour:
- Reset (rst=0, async): o_PE=0, o_busy=0, o_done=0, o_phase=0, step=0, state IDLE.
- States: IDLE, ROW, COL, DONE. Let L = $clog2(SQRT_N).
- Phase sequence: ROW, COL, ROW, ... giving L+1 ROW phases and L COL phases. Each phase lasts SQRT_N cycles (step 0..SQRT_N-1).
- Total sort latency: (2L+1)*SQRT_N cycles from the cycle after i_start to o_done=1.
- Handshake in IDLE/DONE:
  - i_load_valid: o_PE <= i_load_data next edge; o_done cleared.
  - i_start: enter ROW step 0, o_busy=1, o_done=0.
  - Both asserted together: the loaded value is the one sorted.
  - While busy, i_load_valid and i_start are ignored.
- ROW step s:
  - If (s+COL) even, partner is right (exists if COL<SQRT_N-1); otherwise partner is left (exists if COL>0). No partner: hold.
  - Direction: ROW even is ascending left-to-right, ROW odd is descending.
  - Ascending: with right partner keep min(o_PE, i_PE_r); with left partner keep max(i_PE_l, o_PE). Descending swaps min and max.
- COL step s:
  - If (s+ROW) even, partner is down (exists if ROW<SQRT_N-1), else up.
  - Always ascending top-to-bottom: with down partner keep min, with up partner keep max.
- Comparison is unsigned. Equal keys produce no change.
- Last step of the last ROW phase: next state DONE; o_busy=0, o_done=1.
- SQRT_N=1: one ROW step with no partner; key unchanged; o_done after 1 cycle.
- rst asserted mid-sort: immediate return to reset values; the key is lost.

Optional Feature:
- Macro: NANCI_SWAP_COUNT_EN.
- Defined:
  - Adds port o_swap_count (out, 16): number of cycles in which o_PE changed value during the current sort.
  - Cleared on i_start; saturates at 16'hFFFF; reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package nanci_pkg:
  - state enum (IDLE, ROW, COL, DONE);
  - localparam function for phase count 2*$clog2(n)+1.
- Sub-module mesh_cmp_xchg (combinational): inputs self, partner, partner_valid, keep_min; outputs next key and a changed flag.
- PE instantiates mesh_cmp_xchg once, muxing partner and direction from state, step, ROW and COL.

Test Plan:
- Single PE (SQRT_N=1): load 16'h00AB, start -> o_done=1 one cycle later, o_PE=16'h00AB, o_busy low.
- 2x2 harness with keys (0,0)=4, (0,1)=3, (1,0)=2, (1,1)=1, start -> after 6 cycles, row0=[1,2] and row1=[4,3]; o_done=1 on all four PEs.
- 4x4 harness, keys 15..0 in row-major order, start -> after 20 cycles, snake order 0..15 (row1 reads 7,6,5,4); NANCI_SWAP_COUNT_EN count on PE(0,0) is non-zero.
- 2x2 harness, all keys 16'h0007 -> unchanged after 6 cycles; swap count 0.
- 2x2 harness: start, then i_start and i_load_valid=16'h00FF at cycle 2 -> both ignored; result and latency as in the second scenario.
- 2x2 harness: rst low at cycle 3 of a sort -> all o_PE=0, o_busy=0, o_done=0 immediately; reload, then start -> correct snake result.

Source files
------------

// File: rtl/nanci_pkg.sv
// Shared types and helpers for the Nanci mesh sorter PEs.
// Optional build macro: NANCI_SWAP_COUNT_EN (adds a per-PE swap counter).
package nanci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Shearsort phase count: log2(n)+1 row phases interleaved with log2(n) column phases.
  function automatic int num_phases(input int n);
    return 2 * $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mesh_cmp_xchg.sv
// Compare-exchange cell: picks the key this PE keeps after facing one partner.
// Equal keys never count as a change, so ties leave the register untouched.
module mesh_cmp_xchg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] self_i,
  input  logic [DATA_WIDTH-1:0] partner_i,
  input  logic                  partner_valid_i,
  input  logic                  keep_min_i,
  output logic [DATA_WIDTH-1:0] next_o,
  output logic                  changed_o
);

  // Unsigned min/max select against the partner, hold when no partner exists
  always_comb begin
    next_o = self_i;
    if (partner_valid_i) begin
      if (keep_min_i && (partner_i < self_i)) next_o = partner_i;
      if (!keep_min_i && (partner_i > self_i)) next_o = partner_i;
    end
    changed_o = (next_o != self_i);
  end

endmodule

// File: rtl/mesh_sort_pe.sv
// One processing element of the Nanci SQRT_N x SQRT_N shearsort mesh.
// Every PE runs the same sequencer in lockstep; only the partner/direction
// selection depends on the (ROW, COL) position.
// Optional build macro: NANCI_SWAP_COUNT_EN adds o_swap_count.
module mesh_sort_pe
  import nanci_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SQRT_N     = 4,
  parameter int ROW        = 0,
  parameter int COL        = 0,
  parameter int PHASE_W    = 2 * $clog2(SQRT_N) + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load_valid,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_PE_l,
  input  logic [DATA_WIDTH-1:0] i_PE_r,
  input  logic [DATA_WIDTH-1:0] i_PE_u,
  input  logic [DATA_WIDTH-1:0] i_PE_d,
  output logic [DATA_WIDTH-1:0] o_PE,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [PHASE_W-1:0]    o_phase
`ifdef NANCI_SWAP_COUNT_EN
  ,
  output logic [15:0]           o_swap_count
`endif
);

  localparam int STEP_W = (SQRT_N > 1) ? $clog2(SQRT_N) : 1;
  localparam int NPH    = num_phases(SQRT_N);

  localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(SQRT_N - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NPH - 1);

  localparam bit ROW_ODD = (ROW % 2) == 1;
  localparam bit COL_ODD = (COL % 2) == 1;
  localparam bit HAS_L   = COL > 0;
  localparam bit HAS_R   = COL < SQRT_N - 1;
  localparam bit HAS_U   = ROW > 0;
  localparam bit HAS_D   = ROW < SQRT_N - 1;

  state_e                state_q;
  logic [STEP_W-1:0]     step_q;
  logic [PHASE_W-1:0]    phase_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic                  busy_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] partner;
  logic                  partner_vld;
  logic                  keep_min;
  logic [DATA_WIDTH-1:0] key_d;
  logic                  key_chg;

  // Partner and direction select: (step + index) parity picks the forward
  // neighbour; odd rows run descending to form the snake.
  always_comb begin
    partner     = '0;
    partner_vld = 1'b0;
    keep_min    = 1'b1;
    if (state_q == ST_ROW) begin
      if (step_q[0] == COL_ODD) begin
        partner     = i_PE_r;
        partner_vld = HAS_R;
        keep_min    = !ROW_ODD;
      end else begin
        partner     = i_PE_l;
        partner_vld = HAS_L;
        keep_min    = ROW_ODD;
      end
    end else if (state_q == ST_COL) begin
      if (step_q[0] == ROW_ODD) begin
        partner     = i_PE_d;
        partner_vld = HAS_D;
        keep_min    = 1'b1;
      end else begin
        partner     = i_PE_u;
        partner_vld = HAS_U;
        keep_min    = 1'b0;
      end
    end
  end

  mesh_cmp_xchg #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .self_i         (key_q),
    .partner_i      (partner),
    .partner_valid_i(partner_vld),
    .keep_min_i     (keep_min),
    .next_o         (key_d),
    .changed_o      (key_chg)
  );

  // Sequencer: load/start handshake when idle, then row/col phases of SQRT_N steps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      phase_q <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_load_valid) begin
            key_q   <= i_load_data;
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          if (i_start) begin
            state_q <= ST_ROW;
            step_q  <= '0;
            phase_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_ROW, ST_COL: begin
          if (key_chg) key_q <= key_d;
          if (step_q == LAST_STEP) begin
            step_q <= '0;
            if (phase_q == LAST_PHASE) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              phase_q <= phase_q + 1'b1;
              state_q <= (state_q == ST_ROW) ? ST_COL : ST_ROW;
            end
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_PE    = key_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_phase = phase_q;

`ifdef NANCI_SWAP_COUNT_EN
  logic [15:0] swap_q;

  // Saturating count of sort cycles in which the key register changed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swap_q <= '0;
    end else if ((state_q == ST_IDLE || state_q == ST_DONE) && i_start) begin
      swap_q <= '0;
    end else if ((state_q == ST_ROW || state_q == ST_COL) && key_chg && (swap_q != 16'hFFFF)) begin
      swap_q <= swap_q + 16'd1;
    end
  end

  assign o_swap_count = swap_q;
`endif

endmodule
